// File: rtl/pipelined_decode_controller_pkg.sv
// Shared MIPS decode constants, control bundle type and interlock FSM states
// for the ID-stage decode controller.
package MIPSConstants;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] ARCTRL_ZERO = 4'd0;
    localparam logic [3:0] ARCTRL_ADD  = 4'd1;
    localparam logic [3:0] ARCTRL_SUB  = 4'd2;
    localparam logic [3:0] ARCTRL_AND  = 4'd3;
    localparam logic [3:0] ARCTRL_OR   = 4'd4;
    localparam logic [3:0] ARCTRL_XOR  = 4'd5;
    localparam logic [3:0] ARCTRL_SLT  = 4'd6;
    localparam logic [3:0] ARCTRL_LU   = 4'd7;
    localparam logic [3:0] ARCTRL_FUNC = 4'd8;

    localparam logic [1:0] BRANCH_OFF = 2'd0;
    localparam logic [1:0] BRANCH_BEQ = 2'd1;
    localparam logic [1:0] BRANCH_BNE = 2'd2;

    typedef struct packed {
        logic       reg_dst;
        logic       jump;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] branch;
        logic [3:0] arctrl;
        logic       valid;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '{
        reg_dst:    1'b0,
        jump:       1'b0,
        mem_read:   1'b0,
        mem_to_reg: 1'b0,
        mem_write:  1'b0,
        alu_src:    1'b0,
        reg_write:  1'b0,
        branch:     BRANCH_OFF,
        arctrl:     ARCTRL_ZERO,
        valid:      1'b0
    };

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH
    } ctrl_state_t;

    // Unknown opcodes fall through as a valid all-zero NOP bundle.
    function automatic ctrl_bundle_t decode_opcode(input logic [5:0] op);
        ctrl_bundle_t b;
        b       = CTRL_BUBBLE;
        b.valid = 1'b1;
        case (op)
            OP_RTYPE: begin b.reg_dst = 1'b1; b.reg_write = 1'b1; b.arctrl = ARCTRL_FUNC; end
            OP_ADDI:  begin b.alu_src = 1'b1; b.reg_write = 1'b1; b.arctrl = ARCTRL_ADD;  end
            OP_ANDI:  begin b.alu_src = 1'b1; b.reg_write = 1'b1; b.arctrl = ARCTRL_AND;  end
            OP_ORI:   begin b.alu_src = 1'b1; b.reg_write = 1'b1; b.arctrl = ARCTRL_OR;   end
            OP_XORI:  begin b.alu_src = 1'b1; b.reg_write = 1'b1; b.arctrl = ARCTRL_XOR;  end
            OP_SLTI:  begin b.alu_src = 1'b1; b.reg_write = 1'b1; b.arctrl = ARCTRL_SLT;  end
            OP_LUI:   begin b.alu_src = 1'b1; b.reg_write = 1'b1; b.arctrl = ARCTRL_LU;   end
            OP_SW:    begin b.alu_src = 1'b1; b.mem_write = 1'b1; b.arctrl = ARCTRL_ADD;  end
            OP_LW: begin
                b.alu_src    = 1'b1;
                b.mem_read   = 1'b1;
                b.mem_to_reg = 1'b1;
                b.reg_write  = 1'b1;
                b.arctrl     = ARCTRL_ADD;
            end
            OP_BEQ:   begin b.branch = BRANCH_BEQ; b.arctrl = ARCTRL_SUB; end
            OP_BNE:   begin b.branch = BRANCH_BNE; b.arctrl = ARCTRL_SUB; end
            OP_J:     begin b.jump = 1'b1; b.arctrl = ARCTRL_ZERO; end
            default:  ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pipelined_decode_controller_hazard.sv
// Combinational load-use hazard detector: a load in EX whose destination is
// a source of the instruction currently in ID.
module hazard_detector
    import MIPSConstants::*;
#(
    parameter int OPCODE_WIDTH   = 6,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [OPCODE_WIDTH-1:0]   opcode,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_valid,
    input  logic                      ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
    input  logic                      ex_valid,
    output logic                      hazard
);

    logic reads_rt;
    logic rs_match;
    logic rt_match;

    // Only R-type, SW and branches actually read rt as a source.
    assign reads_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) ||
                      (opcode == OP_BEQ)   || (opcode == OP_BNE);
    assign rs_match = (ex_rt == id_rs);
    assign rt_match = (ex_rt == id_rt) && reads_rt;

    assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rt != '0) &&
                    (rs_match || rt_match);

endmodule

// File: rtl/pipelined_decode_controller.sv
// ID-stage decode controller with load-use stall, taken-branch flush and jump
// squash interlocks. Optional CTRL_PERF_COUNTERS_EN adds stall/flush counters.
module pipelined_decode_controller
    import MIPSConstants::*;
#(
    parameter int OPCODE_WIDTH    = 6,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int FLUSH_BUBBLES   = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [OPCODE_WIDTH-1:0]   opcode,
    input  logic [REG_ADDR_WIDTH-1:0] idRs,
    input  logic [REG_ADDR_WIDTH-1:0] idRt,
    input  logic                      idValid,
    input  logic                      exMemRead,
    input  logic [REG_ADDR_WIDTH-1:0] exRt,
    input  logic                      exValid,
    input  logic                      branchTaken,
    output logic                      ctrlRegDst,
    output logic                      ctrlJump,
    output logic                      ctrlMemRead,
    output logic                      ctrlMemToReg,
    output logic                      ctrlMemWrite,
    output logic                      ctrlAluSrc,
    output logic                      ctrlRegWrite,
    output logic [1:0]                ctrlBranch,
    output logic [3:0]                ctrlArctrl,
    output logic                      ctrlValid,
    output logic                      pcWriteEnable,
    output logic                      ifIdWriteEnable,
    output logic                      ifIdFlush
`ifdef CTRL_PERF_COUNTERS_EN
    ,
    output logic [31:0]               stallCycles,
    output logic [31:0]               flushCycles
`endif
);

    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_USE_STALLS - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_BUBBLES - 1);

    ctrl_state_t  state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    ctrl_bundle_t ctrl_q, ctrl_d;
    ctrl_bundle_t decoded;
    logic         hazard;
    logic         pc_we, ifid_we, ifid_flush;

    hazard_detector #(
        .OPCODE_WIDTH   (OPCODE_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard (
        .opcode      (opcode),
        .id_rs       (idRs),
        .id_rt       (idRt),
        .id_valid    (idValid),
        .ex_mem_read (exMemRead),
        .ex_rt       (exRt),
        .ex_valid    (exValid),
        .hazard      (hazard)
    );

    always_comb begin
        decoded       = decode_opcode(opcode);
        decoded.valid = idValid;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctrl_d     = CTRL_BUBBLE;
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;

        // A taken branch overrides every state, including an in-progress stall.
        if (branchTaken) begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            if (FLUSH_BUBBLES > 1) begin
                state_d = FLUSH;
                cnt_d   = FLUSH_RELOAD;
            end else begin
                state_d = RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard) begin
                        if (LOAD_USE_STALLS > 1) begin
                            state_d = STALL;
                            cnt_d   = STALL_RELOAD;
                        end
                    end else begin
                        ctrl_d     = decoded;
                        pc_we      = 1'b1;
                        ifid_we    = 1'b1;
                        ifid_flush = idValid && (opcode == OP_J);
                    end
                end
                STALL: begin
                    if (cnt_q > 3'd1) cnt_d = cnt_q - 3'd1;
                    else              state_d = RUN;
                end
                FLUSH: begin
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b1;
                    if (cnt_q > 3'd1) cnt_d = cnt_q - 3'd1;
                    else              state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ctrl_q  <= CTRL_BUBBLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign pcWriteEnable   = pc_we      && !reset;
    assign ifIdWriteEnable = ifid_we    && !reset;
    assign ifIdFlush       = ifid_flush && !reset;

    assign ctrlRegDst   = ctrl_q.reg_dst;
    assign ctrlJump     = ctrl_q.jump;
    assign ctrlMemRead  = ctrl_q.mem_read;
    assign ctrlMemToReg = ctrl_q.mem_to_reg;
    assign ctrlMemWrite = ctrl_q.mem_write;
    assign ctrlAluSrc   = ctrl_q.alu_src;
    assign ctrlRegWrite = ctrl_q.reg_write;
    assign ctrlBranch   = ctrl_q.branch;
    assign ctrlArctrl   = ctrl_q.arctrl;
    assign ctrlValid    = ctrl_q.valid;

`ifdef CTRL_PERF_COUNTERS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_cycles_q, flush_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_cycles_d = flush_cycles_q;
        if (!pcWriteEnable && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
        if (ifIdFlush && (flush_cycles_q != '1))      flush_cycles_d = flush_cycles_q + 32'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign stallCycles = stall_cycles_q;
    assign flushCycles = flush_cycles_q;
`endif

endmodule

// File: doc/pipelined_decode_controller.md
Name: pipelined_decode_controller

Overview:
- Next-generation instruction-decode controller for the simplified MIPS pipeline.
- Decodes the opcode into the control bundle and registers it into the ID/EX boundary, giving one cycle of latency.
- Owns the pipeline interlocks: load-use stall with a parametrised bubble count, branch-taken flush with a parametrised bubble count, and jump slot squash.
- Sits between the IF/ID register and the EX stage; drives the PC and IF/ID enables.

Parameters:
OPCODE_WIDTH, 6, opcode field width, instruction[31:26].
REG_ADDR_WIDTH, 5, register specifier width.
LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard; legal range 1..7.
FLUSH_BUBBLES, 2, bubbles inserted after a taken branch; legal range 1..7.

Ports:
clock  in  1  pipeline clock.
reset  in  1  asynchronous, active-high reset.
opcode  in  OPCODE_WIDTH  opcode of the instruction in ID.
idRs  in  REG_ADDR_WIDTH  rs of the instruction in ID.
idRt  in  REG_ADDR_WIDTH  rt of the instruction in ID.
idValid  in  1  ID holds a real instruction.
exMemRead  in  1  instruction in EX is a load.
exRt  in  REG_ADDR_WIDTH  destination of the load in EX.
exValid  in  1  EX holds a real instruction.
branchTaken  in  1  branch resolved taken in EX, single-cycle pulse.
ctrlRegDst, ctrlJump, ctrlMemRead, ctrlMemToReg, ctrlMemWrite, ctrlAluSrc, ctrlRegWrite  out  1 each  registered control bits.
ctrlBranch  out  2  registered branch mode (BRANCH_OFF/BEQ/BNE).
ctrlArctrl  out  4  registered ALU control (ARCTRL_*).
ctrlValid  out  1  registered bundle is a real instruction, not a bubble.
pcWriteEnable  out  1  combinational; PC may advance.
ifIdWriteEnable  out  1  combinational; IF/ID may load.
ifIdFlush  out  1  combinational; clear IF/ID to a bubble next edge.

Behaviour:
- Decode table:
  - R: regDst, regWrite, ARCTRL_FUNC.
  - ADDI/ANDI/ORI/XORI/SLTI/LUI: aluSrc, regWrite, with ARCTRL_ADD/AND/OR/XOR/SLT/LU respectively.
  - SW: aluSrc, memWrite, ARCTRL_ADD.
  - LW: aluSrc, memRead, memToReg, regWrite, ARCTRL_ADD.
  - BEQ/BNE: BRANCH_BEQ/BRANCH_BNE, ARCTRL_SUB.
  - J: jump, ARCTRL_ZERO.
  - Unknown opcode: all zero, ARCTRL_ZERO, BRANCH_OFF, ctrlValid=1 (executes as a NOP).
- Bubble: all ctrl* = 0, ctrlArctrl=ARCTRL_ZERO, ctrlBranch=BRANCH_OFF, ctrlValid=0.
- Reset (async):
  - Every ctrl* output is the bubble value.
  - State=RUN, bubble counter=0.
  - While reset is asserted: pcWriteEnable=0, ifIdWriteEnable=0, ifIdFlush=0.
  - Deassertion: normal operation from the next rising edge.
- Hazard definition: hazard = idValid & exValid & exMemRead & (exRt!=0) & ((exRt==idRs) | (exRt==idRt & opcode in {R,SW,BEQ,BNE})).
- FSM states: RUN, STALL, FLUSH. 3-bit down-counter cnt.
- RUN:
  - branchTaken (highest priority): register a bubble; ifIdFlush=1, pcWriteEnable=1.
    - FLUSH_BUBBLES>1: cnt<=FLUSH_BUBBLES-1, go to FLUSH.
    - Otherwise: stay in RUN.
  - Else hazard: register a bubble; pcWriteEnable=0, ifIdWriteEnable=0.
    - LOAD_USE_STALLS>1: cnt<=LOAD_USE_STALLS-1, go to STALL.
    - Otherwise: stay in RUN.
  - Else: register the decoded bundle (ctrlValid=idValid); pcWriteEnable=1, ifIdWriteEnable=1.
    - ifIdFlush=1 when idValid & opcode==J, squashing the fetched slot.
- STALL:
  - Register a bubble; PC and IF/ID held (both enables 0).
  - cnt decrements; at cnt==1 return to RUN.
  - branchTaken in STALL aborts the stall: take the RUN branchTaken action (flush wins).
- FLUSH:
  - Register a bubble; ifIdFlush=1, pcWriteEnable=1, ifIdWriteEnable=1.
  - cnt decrements; at cnt==1 return to RUN.
  - branchTaken in FLUSH reloads cnt<=FLUSH_BUBBLES-1.
- idRs/idRt equal to 0 never cause a hazard.
- The counter never wraps: it is loaded only on entry and reload, and stops at 1.

Optional Feature:
- Macro: CTRL_PERF_COUNTERS_EN.
- Defined:
  - Adds output ports stallCycles[31:0] and flushCycles[31:0], reset to 0.
  - stallCycles increments on every cycle with pcWriteEnable=0 outside reset.
  - flushCycles increments on every cycle with ifIdFlush=1.
  - Both saturate at 0xFFFFFFFF.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package MIPSConstants holds:
  - The opcode constants.
  - ARCTRL_* and BRANCH_*.
  - A new packed struct ctrl_bundle_t for the nine control fields plus valid.
  - A new CTRL_BUBBLE constant.
  - A new ctrl_state_t enum {RUN, STALL, FLUSH}.
- One sub-module, hazard_detector: purely combinational hazard equation, instantiated once.

Test Plan:
- Reset mid-stream: assert reset with state=STALL, cnt=2 -> ctrlValid=0, both enables 0 immediately; state=RUN after release.
- ADDI (opcode 0x08), idValid=1 -> next edge ctrlAluSrc=1, ctrlRegWrite=1, ctrlArctrl=ARCTRL_ADD, ctrlValid=1.
- LW in EX with exRt=5, R-type in ID with idRt=5, LOAD_USE_STALLS=3 -> exactly 3 bubble cycles with pcWriteEnable=0, then the R bundle issues.
- Same as the previous case but exRt=0, or an ADDI in ID using rt=5 -> no stall.
- branchTaken during the 2nd stall cycle, FLUSH_BUBBLES=2 -> ifIdFlush=1 for 2 cycles, stall aborted, pcWriteEnable=1.
- J in ID -> ifIdFlush=1 for 1 cycle, next edge ctrlJump=1; with CTRL_PERF_COUNTERS_EN, flushCycles increments by 1.
